// File: rtl/syscall_unit_pkg.sv
// syscall_unit_pkg: service codes, FSM states, POW10 ROM and ASCII constants shared by the syscall unit
package syscall_unit_pkg;
    localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
    localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
    localparam logic [31:0] SYS_EXIT       = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
    localparam logic [31:0] SYS_EXIT2      = 32'd17;
    localparam logic [31:0] SYS_PRINT_HEX  = 32'd34;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_X     = 8'h78;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    typedef enum logic [2:0] {IDLE, DEC, HEX, STR_REQ, STR_WAIT, DRAIN, DONE, HALT} state_t;
    localparam logic [31:0] POW10 [10] = '{
        32'd1000000000, 32'd100000000, 32'd10000000, 32'd1000000, 32'd100000,
        32'd10000, 32'd1000, 32'd100, 32'd10, 32'd1
    };
endpackage

// File: rtl/syscall_char_fifo.sv
// syscall_char_fifo: synchronous 8-bit console character FIFO
//   clk, rst          clock, synchronous active-high flush
//   push, din         write request and char (ignored while full)
//   pop               read request (ignored while empty)
//   full, empty, dout status flags and head char
module syscall_char_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] dout
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    // extra pointer bit distinguishes full from empty when the indices match
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/syscall_unit.sv
// syscall_unit: decodes v0/a0 syscalls, stalls the pipeline and streams console chars
//   clk, rst                      clock, synchronous active-high reset
//   sig_syscall, v0, a0           syscall request, service code, argument
//   stall                         freeze pipeline
//   mem_req, mem_addr, mem_ack,
//   mem_rdata                     byte read port for string fetch
//   con_valid, con_data, con_ready console sink handshake
//   halted, exit_code             sticky exit status
// Define SYSCALL_FINISH_EN to print "exit <code>" and $finish on entry to HALT (simulation only).
module syscall_unit
    import syscall_unit_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int MAX_STR_LEN = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sig_syscall,
    input  logic [31:0]       v0,
    input  logic [31:0]       a0,
    output logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              con_valid,
    output logic [7:0]        con_data,
    input  logic              con_ready,
    output logic              halted,
    output logic [31:0]       exit_code
);
    localparam int CW = $clog2(MAX_STR_LEN + 1);
    state_t state, nxt;
    logic [31:0] rem, pow;
    logic neg, seen, push, full, empty, emit, known, is_char;
    logic [3:0] pidx, digit, hcnt, nib;
    logic [7:0] pdata;
    logic [ADDR_W-1:0] addr;
    logic [CW-1:0] count;
    assign pow = POW10[pidx];
    // leading zeros are dropped until a nonzero digit appears; the units digit always prints
    assign emit = seen | (digit != 4'd0) | (pidx == 4'd9);
    // hcnt 2..9 selects nibbles 7..0
    assign nib = 4'(a0 >> {4'd9 - hcnt, 2'b00});
    assign is_char = v0 == SYS_PRINT_CHAR;
    assign known = is_char | (v0 == SYS_PRINT_INT) | (v0 == SYS_PRINT_STR) | (v0 == SYS_PRINT_HEX)
                 | (v0 == SYS_EXIT) | (v0 == SYS_EXIT2);
    assign stall = (state == HALT)
                 | (sig_syscall & (state != DONE) & !((state == IDLE) & ((is_char & !full) | !known)));
    assign mem_req = state == STR_WAIT;
    assign mem_addr = addr;
    assign con_valid = !empty;
    always_comb begin
        nxt = state;
        push = 1'b0;
        pdata = '0;
        case (state)
            IDLE: if (sig_syscall) begin
                push = is_char;
                pdata = a0[7:0];
                nxt = (v0 == SYS_PRINT_INT) ? DEC
                    : (v0 == SYS_PRINT_HEX) ? HEX
                    : (v0 == SYS_PRINT_STR) ? STR_REQ
                    : (v0 == SYS_EXIT || v0 == SYS_EXIT2) ? DRAIN : IDLE;
            end
            DEC: if (neg) begin
                push = 1'b1;
                pdata = CH_MINUS;
            end else if (rem < pow) begin
                push = emit;
                pdata = CH_0 + {4'd0, digit};
                if (pidx == 4'd9 && !full) nxt = DONE;
            end
            HEX: begin
                push = 1'b1;
                pdata = (hcnt == 4'd0) ? CH_0 : (hcnt == 4'd1) ? CH_X
                      : (nib < 4'd10) ? CH_0 + {4'd0, nib} : CH_A - 8'd10 + {4'd0, nib};
                if (hcnt == 4'd9 && !full) nxt = DONE;
            end
            STR_REQ: if (!full) nxt = STR_WAIT;
            STR_WAIT: if (mem_ack) begin
                push = mem_rdata != 8'd0;
                pdata = mem_rdata;
                nxt = (mem_rdata == 8'd0 || count == CW'(MAX_STR_LEN - 1)) ? DONE : STR_REQ;
            end
            DRAIN: if (empty) nxt = HALT;
            DONE: nxt = IDLE;
            default: nxt = state;
        endcase
    end
    always_ff @(posedge clk)
        state <= rst ? IDLE : nxt;
    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            neg <= 1'b0;
            seen <= 1'b0;
            pidx <= '0;
            digit <= '0;
            hcnt <= '0;
            addr <= '0;
            count <= '0;
            exit_code <= '0;
            halted <= 1'b0;
        end else begin
            if (state == IDLE) begin
                rem <= a0[31] ? -a0 : a0;
                neg <= a0[31];
                seen <= 1'b0;
                pidx <= '0;
                digit <= '0;
                hcnt <= '0;
                count <= '0;
                if (sig_syscall && v0 == SYS_PRINT_STR) addr <= ADDR_W'(a0);
            end
            if (state == DEC) begin
                if (neg) neg <= full;
                else if (rem >= pow) begin
                    rem <= rem - pow;
                    digit <= digit + 4'd1;
                end else if (!emit || !full) begin
                    pidx <= pidx + 4'd1;
                    digit <= '0;
                    seen <= seen | emit;
                end
            end
            if (state == HEX && !full) hcnt <= hcnt + 4'd1;
            if (state == STR_WAIT && mem_ack && mem_rdata != 8'd0) begin
                addr <= addr + ADDR_W'(1);
                count <= count + CW'(1);
            end
            if (state == DRAIN && empty) begin
                exit_code <= (v0 == SYS_EXIT) ? '0 : a0;
                halted <= 1'b1;
            end
        end
    end
    syscall_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (pdata),
        .pop  (con_ready),
        .full (full),
        .empty(empty),
        .dout (con_data)
    );
`ifdef SYSCALL_FINISH_EN
    always @(posedge clk)
        if (!rst && state == DRAIN && nxt == HALT) begin
            $display("exit %0d", (v0 == SYS_EXIT) ? 32'd0 : a0);
            $finish;
        end
`else
`endif
endmodule

// File: tb/tb_syscall_unit.sv
// tb_syscall_unit: directed vector bench for syscall_unit with console sink and byte memory models
module tb_syscall_unit;
    typedef struct {
        logic [31:0] v0;
        logic [31:0] a0;
        string       exp;
        bit          stalls;
    } vec_t;
    logic clk = 0, rst = 1, sig_syscall = 0, mem_ack = 0, con_ready = 0;
    logic [31:0] v0 = 0, a0 = 0, mem_addr, exit_code, last_addr = 0;
    logic [7:0] mem_rdata = 0, con_data;
    logic stall, mem_req, con_valid, halted, hold = 0;
    int vectors = 0, miscompares = 0, mem_delay = 0, wait_cnt = 0, addr_glitches = 0;
    logic [7:0] rx[$];
    vec_t vecs [12];
    always #5 clk = ~clk;
    syscall_unit #(.FIFO_DEPTH(16), .MAX_STR_LEN(256), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .sig_syscall(sig_syscall), .v0(v0), .a0(a0), .stall(stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
        .halted(halted), .exit_code(exit_code)
    );
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (a == 32'h1000) return 8'h48;
        if (a == 32'h1001) return 8'h69;
        if (a == 32'hFFFF_FFFF) return 8'h5A;
        if (a == 32'h0) return 8'h51;
        if (a >= 32'h2000 && a < 32'h2000 + 300) return 8'h61 + 8'((a - 32'h2000) % 26);
        return 8'h00;
    endfunction
    // sink and memory model act mid-cycle, well away from the rising edge
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst && con_valid && con_ready) rx.push_back(con_data);
        if (hold && mem_req && mem_addr != last_addr) addr_glitches++;
        if (mem_req && !rst) begin
            if (wait_cnt >= mem_delay) begin
                mem_ack = 1;
                mem_rdata = mem_byte(mem_addr);
                wait_cnt = 0;
            end else begin
                mem_ack = 0;
                wait_cnt++;
            end
        end else begin
            mem_ack = 0;
            wait_cnt = 0;
        end
        hold = mem_req && !mem_ack;
        last_addr = mem_addr;
    end
    function automatic string clip(input string s);
        return (s.len() > 40) ? s.substr(0, 39) : s;
    endfunction
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask
    task automatic check_s(input string name, input string got, input string exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got len %0d \"%s\" expected len %0d \"%s\"", name, got.len(), clip(got),
                     exp.len(), clip(exp));
        end
    endtask
    task automatic call(input logic [31:0] c, input logic [31:0] a, output int sc);
        bit done = 0;
        sc = 0;
        @(negedge clk);
        sig_syscall = 1;
        v0 = c;
        a0 = a;
        #1;
        for (int i = 0; i < 5000 && !done; i++) begin
            if (!stall) begin
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                sc++;
                @(negedge clk);
                #1;
            end
        end
        sig_syscall = 0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL call_timeout: v0=%0d still stalled, required release", c);
        end
    endtask
    task automatic collect(input int n, output string s);
        for (int i = 0; i < 3000 && rx.size() < n; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        s = "";
        foreach (rx[i]) s = $sformatf("%s%c", s, rx[i]);
        rx.delete();
    endtask
    task automatic do_reset();
        @(negedge clk);
        sig_syscall = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", {31'd0, stall}, 0);
        check("rst_mem_req", {31'd0, mem_req}, 0);
        check("rst_con_valid", {31'd0, con_valid}, 0);
        check("rst_halted", {31'd0, halted}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_exit_code", exit_code, 0);
        rst = 0;
    endtask
    initial begin
        int sc, n;
        string got, exp;
        vecs[0]  = '{32'd11, 32'h41, "A", 1'b0};
        vecs[1]  = '{32'd1, 32'h8000_0000, "-2147483648", 1'b1};
        vecs[2]  = '{32'd1, 32'd0, "0", 1'b1};
        vecs[3]  = '{32'd1, 32'd1000, "1000", 1'b1};
        vecs[4]  = '{32'd1, 32'hFFFF_FFFF, "-1", 1'b1};
        vecs[5]  = '{32'd1, 32'h7FFF_FFFF, "2147483647", 1'b1};
        vecs[6]  = '{32'd1, 32'd1000000000, "1000000000", 1'b1};
        vecs[7]  = '{32'd34, 32'h0000_001F, "0x0000001F", 1'b1};
        vecs[8]  = '{32'd4, 32'h1000, "Hi", 1'b1};
        vecs[9]  = '{32'd4, 32'hFFFF_FFFF, "ZQ", 1'b1};
        vecs[10] = '{32'd4, 32'h1002, "", 1'b1};
        vecs[11] = '{32'd99, 32'd5, "", 1'b0};
        do_reset();
        con_ready = 1;
        mem_delay = 3;
        foreach (vecs[i]) begin
            call(vecs[i].v0, vecs[i].a0, sc);
            collect(vecs[i].exp.len(), got);
            check_s($sformatf("vec%0d_text", i), got, vecs[i].exp);
            check($sformatf("vec%0d_stalled", i), {31'd0, sc > 0}, {31'd0, vecs[i].stalls});
        end
        check("addr_stable", addr_glitches, 0);
        // stall is low for one DONE cycle, then a still-asserted syscall is decoded afresh
        @(negedge clk);
        sig_syscall = 1;
        v0 = 1;
        a0 = 5;
        #1;
        for (int i = 0; i < 100 && stall; i++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        check("done_one_cycle", {31'd0, stall}, 1);
        sig_syscall = 0;
        collect(1, got);
        check_s("done_single_exec", got, "5");
        // fill the FIFO with the sink stalled
        con_ready = 0;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            call(32'd11, 32'h61 + i, sc);
            n += sc;
        end
        check("fill_no_stall", n, 0);
        @(negedge clk);
        sig_syscall = 1;
        v0 = 11;
        a0 = 32'h71;
        #1;
        check("full_stall", {31'd0, stall}, 1);
        check("full_head", {24'd0, con_data}, 32'h61);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            n += stall ? 1 : 0;
        end
        check("full_stall_held", n, 3);
        @(negedge clk);
        con_ready = 1;
        #1;
        check("full_pop_cycle_stall", {31'd0, stall}, 1);
        for (int i = 0; i < 20 && stall; i++) begin
            @(negedge clk);
            #1;
        end
        check("full_released", {31'd0, stall}, 0);
        @(posedge clk);
        #1;
        sig_syscall = 0;
        for (int i = 0; i < 3; i++) call(32'd11, 32'h72 + i, sc);
        collect(20, got);
        check_s("full_order", got, "abcdefghijklmnopqrst");
        // reset while a string read is outstanding
        con_ready = 0;
        call(32'd11, 32'h7A, sc);
        mem_delay = 20;
        @(negedge clk);
        sig_syscall = 1;
        v0 = 4;
        a0 = 32'h1000;
        for (int i = 0; i < 10 && !mem_req; i++) begin
            @(negedge clk);
            #1;
        end
        repeat (2) @(negedge clk);
        #1;
        check("str_wait_req", {31'd0, mem_req}, 1);
        rst = 1;
        sig_syscall = 0;
        @(negedge clk);
        #1;
        check("abort_mem_req", {31'd0, mem_req}, 0);
        check("abort_con_valid", {31'd0, con_valid}, 0);
        rst = 0;
        mem_delay = 0;
        rx.delete();
        con_ready = 1;
        call(32'd34, 32'hDEAD_BEEF, sc);
        collect(10, got);
        check_s("hex_after_abort", got, "0xDEADBEEF");
        // unterminated string is cut at MAX_STR_LEN
        call(32'd4, 32'h2000, sc);
        collect(256, got);
        exp = "";
        for (int i = 0; i < 256; i++) exp = $sformatf("%s%c", exp, 8'h61 + 8'(i % 26));
        check_s("str_max_len", got, exp);
        // exit 17 waits for the queue to drain
        con_ready = 0;
        for (int i = 0; i < 5; i++) call(32'd11, 32'h76 + i, sc);
        @(negedge clk);
        sig_syscall = 1;
        v0 = 17;
        a0 = 7;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            n += (stall && !halted) ? 1 : 0;
        end
        check("drain_waits", n, 3);
        con_ready = 1;
        for (int i = 0; i < 50 && !halted; i++) begin
            @(negedge clk);
            #1;
        end
        check("halt_rise", {31'd0, halted}, 1);
        check("halt_after_pops", rx.size(), 5);
        check("exit17_code", exit_code, 7);
        sig_syscall = 0;
        #1;
        check("halt_stall", {31'd0, stall}, 1);
        collect(5, got);
        check_s("drain_text", got, "vwxyz");
        do_reset();
        @(negedge clk);
        sig_syscall = 1;
        v0 = 10;
        a0 = 32'h55;
        for (int i = 0; i < 50 && !halted; i++) begin
            @(negedge clk);
            #1;
        end
        check("exit10_halt", {31'd0, halted}, 1);
        check("exit10_code", exit_code, 0);
        sig_syscall = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
